id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
// ID->EX pipeline register for the 64-bit LEGv8 datapath; sits directly downstream of regfile.
// Captures ReadData1/ReadData2 and bypasses them with in-flight EX/MEM/WB results.
// Forces XZR (X31) reads to zero; detects load-use hazards and requests a one-cycle decode stall.
// Presents registered operands and control to the ALU stage.
// PARAMETERS
// DATA_W    64   operand / result width
// REG_AW    5    register-number width
// ZERO_REG  31   register number that always reads 0 and is never a forwarding match
// PORTS
// clk            in   1       rising-edge clock
// reset          in   1       synchronous, active-high; clears every stage register
// id_valid       in   1       decode-stage instruction valid
// id_rn, id_rm   in   REG_AW  source register numbers (same values driven to regfile ReadRegister1/2)
// id_use_rn/rm   in   1       instruction actually reads rn / rm
// rf_data1/2     in   DATA_W  regfile ReadData1 / ReadData2
// id_rd          in   REG_AW  destination register
// id_reg_write   in   1       instruction writes rd
// id_mem_read    in   1       instruction is a load
// ex_result      in   DATA_W  ALU result of instruction currently in EX
// mem_rd         in   REG_AW  destination register of the MEM-stage instruction
// mem_reg_write  in   1       MEM-stage instruction writes mem_rd
// mem_result     in   DATA_W  MEM-stage result
// wb_rd          in   REG_AW  destination register of the WB-stage instruction
// wb_reg_write   in   1       WB-stage instruction writes wb_rd
// wb_result      in   DATA_W  WB-stage result
// hold_in        in   1       downstream stall; freeze this stage
// flush          in   1       squash the instruction entering EX (branch taken)
// ex_valid       out  1       EX-stage instruction valid
// ex_op_a/b      out  DATA_W  registered, forwarded operands
// ex_rn, ex_rm, ex_rd  out  REG_AW  registered register numbers
// ex_reg_write, ex_mem_read  out  1  registered control
// id_hold        out  1       combinational; IF/ID must not advance this cycle
// BEHAVIOUR
// - Latency: 1 cycle from ID inputs to ex_* outputs. All ex_* outputs are 0 after reset.
// - Operand select, per source register s, in priority order:
//   - s==ZERO_REG -> 0
//   - ex_valid & ex_reg_write & !ex_mem_read & ex_rd==s -> ex_result
//   - mem_reg_write & mem_rd==s -> mem_result
//   - wb_reg_write & wb_rd==s -> wb_result (covers regfile same-cycle write/read)
//   - else rf_data
// - A destination equal to ZERO_REG never matches.
// - load_use = id_valid & ex_valid & ex_mem_read & ex_reg_write & ex_rd!=ZERO_REG
//   & ((id_use_rn & ex_rd==id_rn) | (id_use_rm & ex_rd==id_rm)).
// - id_hold = load_use | hold_in.
// - Register update priority per edge:
//   - reset: all cleared.
//   - flush: ex_valid, ex_reg_write, ex_mem_read <= 0; data fields don't-care (hold).
//   - hold_in: every field holds its value.
//   - load_use: bubble; control bits <= 0, data fields hold.
//   - else: capture ID fields; ex_valid <= id_valid. If !id_valid, control bits <= 0.
// - Load-use resolves in exactly 1 bubble: next cycle the load is in MEM and is forwarded via mem_result.
// - Simultaneous flush and hold_in: flush wins.
// - Reset mid-stall: stage empties; id_hold follows hold_in only.
// STRUCTURE
// - Shared cpu_pkg holds: DATA_W, REG_AW, XZR = 5'd31, and
//   typedef enum {FWD_RF, FWD_EX, FWD_MEM, FWD_WB, FWD_ZERO} fwd_sel_e.
// - One sub-module, operand_fwd_sel (priority compare + 5:1 mux, emits fwd_sel_e), instantiated twice (rn, rm).
// - Stage flops and hazard logic live in the top module.
// TESTING
// - Plain capture: rn=3, rf_data1=0xA, no writers -> next cycle ex_op_a=0xA, ex_valid=1.
// - XZR: rn=31, rf_data1=0xDEAD, wb_rd=31 with wb_reg_write=1 -> ex_op_a=0.
// - Priority: rm=5 matched by EX (0x1), MEM (0x2) and WB (0x3) -> ex_op_b=0x1. Drop EX -> 0x2. Drop MEM -> 0x3.
// - Load-use: LDUR X2 in EX, ADD using X2 in ID -> id_hold=1 for one cycle and ex_valid=0 bubble.
//   Next cycle mem_result=0x55 -> ex_op_a=0x55.
// - hold_in=1 for 3 cycles -> all ex_* outputs stable. flush and hold_in together -> ex_valid=0.
// - Reset asserted during load-use stall -> all ex_* outputs 0 next edge; id_hold=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared datapath definitions for the 64-bit LEGv8 pipeline.
//   DATA_W    : operand / result width
//   REG_AW    : register-number width
//   XZR       : register number that reads as zero and is never a write target
//   fwd_sel_e : operand source chosen by the bypass network
package cpu_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned REG_AW = 5;
    localparam logic [REG_AW-1:0] XZR = 5'd31;

    typedef enum logic [2:0] {
        FWD_RF,
        FWD_EX,
        FWD_MEM,
        FWD_WB,
        FWD_ZERO
    } fwd_sel_e;

endpackage

// File: rtl/operand_fwd_sel.sv
// Bypass selection for one source operand.
// Picks the operand from, in priority order: zero (XZR), the EX-stage ALU result,
// the MEM-stage result, the WB-stage result, and finally the regfile read data.
// Ports:
//   src                          : source register number being read
//   rfData                       : regfile read data for src
//   exValid/exRegWrite/exMemRead : control of the instruction in EX
//   exRd/exResult                : destination and ALU result of the instruction in EX
//   memRegWrite/memRd/memResult  : MEM-stage writer
//   wbRegWrite/wbRd/wbResult     : WB-stage writer
//   sel                          : chosen source
//   operand                      : forwarded operand value
module operand_fwd_sel
    import cpu_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  logic [DATA_W-1:0] rfData,
    input  logic              exValid,
    input  logic              exRegWrite,
    input  logic              exMemRead,
    input  logic [REG_AW-1:0] exRd,
    input  logic [DATA_W-1:0] exResult,
    input  logic              memRegWrite,
    input  logic [REG_AW-1:0] memRd,
    input  logic [DATA_W-1:0] memResult,
    input  logic              wbRegWrite,
    input  logic [REG_AW-1:0] wbRd,
    input  logic [DATA_W-1:0] wbResult,
    output fwd_sel_e          sel,
    output logic [DATA_W-1:0] operand
);

    // XZR is tested first, so a writer targeting XZR can never match.
    // A load in EX has no result yet; it is handled by the load-use stall instead.
    always_comb begin
        sel = FWD_RF;
        if (src == XZR) begin
            sel = FWD_ZERO;
        end else if (exValid && exRegWrite && !exMemRead && (exRd == src)) begin
            sel = FWD_EX;
        end else if (memRegWrite && (memRd == src)) begin
            sel = FWD_MEM;
        end else if (wbRegWrite && (wbRd == src)) begin
            sel = FWD_WB;
        end
    end

    always_comb begin
        operand = rfData;
        unique case (sel)
            FWD_ZERO: operand = '0;
            FWD_EX:   operand = exResult;
            FWD_MEM:  operand = memResult;
            FWD_WB:   operand = wbResult;
            default:  operand = rfData;
        endcase
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID->EX pipeline register with operand bypassing and load-use detection.
// Captures regfile read data, replaces it with in-flight EX/MEM/WB results where a
// newer value exists, and presents registered operands and control to EX one cycle later.
// Ports:
//   clk, reset (sync, active-high)
//   id_*             : decode-stage instruction fields and regfile read data
//   ex_result        : ALU result of the instruction in EX
//   mem_* / wb_*     : destination, write enable and result of the MEM / WB instructions
//   hold_in          : downstream stall, freezes this stage
//   flush            : squash the instruction entering EX
//   ex_*             : registered operands, register numbers and control
//   id_hold          : combinational; IF/ID must not advance this cycle
module id_ex_operand_stage
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rn,
    input  logic [REG_AW-1:0] id_rm,
    input  logic              id_use_rn,
    input  logic              id_use_rm,
    input  logic [DATA_W-1:0] rf_data1,
    input  logic [DATA_W-1:0] rf_data2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic [DATA_W-1:0] wb_result,
    input  logic              hold_in,
    input  logic              flush,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_op_a,
    output logic [DATA_W-1:0] ex_op_b,
    output logic [REG_AW-1:0] ex_rn,
    output logic [REG_AW-1:0] ex_rm,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              id_hold
);

    localparam logic [REG_AW-1:0] ZERO_REG = XZR;

    fwd_sel_e          fwdSelA;
    fwd_sel_e          fwdSelB;
    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opB;
    logic              loadUse;

    operand_fwd_sel uFwdA (
        .src         (id_rn),
        .rfData      (rf_data1),
        .exValid     (ex_valid),
        .exRegWrite  (ex_reg_write),
        .exMemRead   (ex_mem_read),
        .exRd        (ex_rd),
        .exResult    (ex_result),
        .memRegWrite (mem_reg_write),
        .memRd       (mem_rd),
        .memResult   (mem_result),
        .wbRegWrite  (wb_reg_write),
        .wbRd        (wb_rd),
        .wbResult    (wb_result),
        .sel         (fwdSelA),
        .operand     (opA)
    );

    operand_fwd_sel uFwdB (
        .src         (id_rm),
        .rfData      (rf_data2),
        .exValid     (ex_valid),
        .exRegWrite  (ex_reg_write),
        .exMemRead   (ex_mem_read),
        .exRd        (ex_rd),
        .exResult    (ex_result),
        .memRegWrite (mem_reg_write),
        .memRd       (mem_rd),
        .memResult   (mem_result),
        .wbRegWrite  (wb_reg_write),
        .wbRd        (wb_rd),
        .wbResult    (wb_result),
        .sel         (fwdSelB),
        .operand     (opB)
    );

    // A load in EX whose destination is needed now: its data only appears next cycle
    // (from MEM), so one bubble is inserted. Gated by reset because the stage is being
    // emptied, so a stall would only hold IF/ID for nothing.
    always_comb begin
        loadUse = !reset && id_valid && ex_valid && ex_mem_read && ex_reg_write
                  && (ex_rd != ZERO_REG)
                  && ((id_use_rn && (ex_rd == id_rn)) || (id_use_rm && (ex_rd == id_rm)));
        id_hold = loadUse || hold_in;
    end

    // Flush beats hold_in; on flush and bubble only control is cleared, data holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            ex_op_a      <= '0;
            ex_op_b      <= '0;
            ex_rn        <= '0;
            ex_rm        <= '0;
            ex_rd        <= '0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
        end else if (flush) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
        end else if (hold_in) begin
            ex_valid     <= ex_valid;
        end else if (loadUse) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
        end else begin
            ex_valid     <= id_valid;
            ex_op_a      <= opA;
            ex_op_b      <= opB;
            ex_rn        <= id_rn;
            ex_rm        <= id_rm;
            ex_rd        <= id_rd;
            ex_reg_write <= id_valid && id_reg_write;
            ex_mem_read  <= id_valid && id_mem_read;
        end
    end

    // Sanity: a zero select must always yield a zero operand.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ((fwdSelA != FWD_ZERO) || (opA == '0));
            assert ((fwdSelB != FWD_ZERO) || (opB == '0));
        end
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: the stimulus side runs a reference model
// and queues the expected stage contents; a monitor pops and compares after each edge.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, id_valid, id_use_rn, id_use_rm, id_reg_write, id_mem_read;
    logic [4:0]  id_rn, id_rm, id_rd, mem_rd, wb_rd;
    logic [63:0] rf_data1, rf_data2, ex_result, mem_result, wb_result;
    logic        mem_reg_write, wb_reg_write, hold_in, flush;
    logic        ex_valid, ex_reg_write, ex_mem_read, id_hold;
    logic [63:0] ex_op_a, ex_op_b;
    logic [4:0]  ex_rn, ex_rm, ex_rd;

    id_ex_operand_stage dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_rn         (id_rn),
        .id_rm         (id_rm),
        .id_use_rn     (id_use_rn),
        .id_use_rm     (id_use_rm),
        .rf_data1      (rf_data1),
        .rf_data2      (rf_data2),
        .id_rd         (id_rd),
        .id_reg_write  (id_reg_write),
        .id_mem_read   (id_mem_read),
        .ex_result     (ex_result),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_result    (mem_result),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_result     (wb_result),
        .hold_in       (hold_in),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_op_a       (ex_op_a),
        .ex_op_b       (ex_op_b),
        .ex_rn         (ex_rn),
        .ex_rm         (ex_rm),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .id_hold       (id_hold)
    );

    typedef struct packed {
        logic        v;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
    } st_t;

    st_t m = '0;
    st_t q[$];
    int  tests = 0;
    int  fails = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Newest writer wins: EX (non-load, valid), then MEM, then WB; XZR always reads 0.
    function automatic logic [63:0] pick(logic [4:0] s, logic [63:0] rf);
        logic        en [3];
        logic [4:0]  rd [3];
        logic [63:0] val[3];
        if (s == 5'd31) return 64'd0;
        en[0] = m.v && m.rw && !m.mr; rd[0] = m.rd;   val[0] = ex_result;
        en[1] = mem_reg_write;        rd[1] = mem_rd; val[1] = mem_result;
        en[2] = wb_reg_write;         rd[2] = wb_rd;  val[2] = wb_result;
        for (int i = 0; i < 3; i++) begin
            if (en[i] && rd[i] == s) return val[i];
        end
        return rf;
    endfunction

    function automatic logic modelLoadUse();
        logic needs;
        needs = (id_use_rn && id_rn == m.rd) || (id_use_rm && id_rm == m.rd);
        return !reset && id_valid && m.v && m.mr && m.rw && m.rd != 5'd31 && needs;
    endfunction

    // Inputs are already driven (just after a negedge); check id_hold, queue the
    // expected post-edge state and move to the next negedge.
    task automatic cycle();
        st_t n;
        #1;
        chk("id_hold", {63'd0, id_hold}, {63'd0, modelLoadUse() || hold_in});
        n = m;
        if (reset) begin
            n = '0;
        end else if (flush) begin
            n.v = 1'b0; n.rw = 1'b0; n.mr = 1'b0;
        end else if (hold_in) begin
            n = m;
        end else if (modelLoadUse()) begin
            n.v = 1'b0; n.rw = 1'b0; n.mr = 1'b0;
        end else begin
            n.a  = pick(id_rn, rf_data1);
            n.b  = pick(id_rm, rf_data2);
            n.rn = id_rn; n.rm = id_rm; n.rd = id_rd;
            n.v  = id_valid;
            n.rw = id_valid && id_reg_write;
            n.mr = id_valid && id_mem_read;
        end
        m = n;
        q.push_back(n);
        @(negedge clk);
    endtask

    task automatic clr();
        reset = 0; id_valid = 0; id_use_rn = 0; id_use_rm = 0; id_reg_write = 0;
        id_mem_read = 0; id_rn = 0; id_rm = 0; id_rd = 0; mem_rd = 0; wb_rd = 0;
        rf_data1 = 0; rf_data2 = 0; ex_result = 0; mem_result = 0; wb_result = 0;
        mem_reg_write = 0; wb_reg_write = 0; hold_in = 0; flush = 0;
    endtask

    function automatic logic [4:0] rndReg();
        int unsigned r;
        r = $urandom_range(0, 5);
        return (r == 5) ? 5'd31 : 5'(r);
    endfunction

    task automatic rnd();
        reset = ($urandom_range(0, 99) == 0);
        id_valid = ($urandom_range(0, 4) != 0);
        id_use_rn = $urandom_range(0, 1) == 1; id_use_rm = $urandom_range(0, 1) == 1;
        id_reg_write = $urandom_range(0, 1) == 1; id_mem_read = ($urandom_range(0, 2) == 0);
        id_rn = rndReg(); id_rm = rndReg(); id_rd = rndReg();
        mem_rd = rndReg(); wb_rd = rndReg();
        mem_reg_write = $urandom_range(0, 1) == 1; wb_reg_write = $urandom_range(0, 1) == 1;
        rf_data1 = {$urandom, $urandom}; rf_data2 = {$urandom, $urandom};
        ex_result = {$urandom, $urandom}; mem_result = {$urandom, $urandom};
        wb_result = {$urandom, $urandom};
        hold_in = ($urandom_range(0, 5) == 0); flush = ($urandom_range(0, 9) == 0);
    endtask

    // Monitor: compare the registered outputs against the queued expectation.
    always @(posedge clk) begin
        st_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("ex_valid", {63'd0, ex_valid}, {63'd0, e.v});
            chk("ex_op_a", ex_op_a, e.a);
            chk("ex_op_b", ex_op_b, e.b);
            chk("ex_rn", {59'd0, ex_rn}, {59'd0, e.rn});
            chk("ex_rm", {59'd0, ex_rm}, {59'd0, e.rm});
            chk("ex_rd", {59'd0, ex_rd}, {59'd0, e.rd});
            chk("ex_reg_write", {63'd0, ex_reg_write}, {63'd0, e.rw});
            chk("ex_mem_read", {63'd0, ex_mem_read}, {63'd0, e.mr});
        end
    end

    initial begin
        logic [63:0] savedA;
        int          waitCnt;
        clr();
        reset = 1;
        @(negedge clk);
        cycle();
        chk("reset_valid", {63'd0, ex_valid}, 64'd0);
        chk("reset_op_a", ex_op_a, 64'd0);

        // Plain capture
        clr(); id_valid = 1; id_rn = 3; id_use_rn = 1; rf_data1 = 64'hA;
        cycle();
        chk("plain_op_a", ex_op_a, 64'hA);
        chk("plain_valid", {63'd0, ex_valid}, 64'd1);

        // XZR reads zero even when WB writes X31
        clr(); id_valid = 1; id_rn = 31; id_use_rn = 1; rf_data1 = 64'hDEAD;
        wb_rd = 31; wb_reg_write = 1; wb_result = 64'h77;
        cycle();
        chk("xzr_op_a", ex_op_a, 64'd0);

        // Priority EX > MEM > WB on rm=5
        clr(); id_valid = 1; id_rd = 5; id_reg_write = 1;
        cycle();
        clr(); id_valid = 1; id_rm = 5; id_use_rm = 1; rf_data2 = 64'h99;
        ex_result = 64'h1; mem_rd = 5; mem_reg_write = 1; mem_result = 64'h2;
        wb_rd = 5; wb_reg_write = 1; wb_result = 64'h3;
        cycle();
        chk("prio_ex", ex_op_b, 64'h1);
        cycle();
        chk("prio_mem", ex_op_b, 64'h2);
        mem_reg_write = 0;
        cycle();
        chk("prio_wb", ex_op_b, 64'h3);

        // Load-use: LDUR X2 then ADD using X2
        clr(); id_valid = 1; id_rd = 2; id_reg_write = 1; id_mem_read = 1;
        cycle();
        clr(); id_valid = 1; id_rn = 2; id_use_rn = 1; id_rd = 4; id_reg_write = 1;
        #1 chk("lu_hold", {63'd0, id_hold}, 64'd1);
        cycle();
        chk("lu_bubble", {63'd0, ex_valid}, 64'd0);
        mem_rd = 2; mem_reg_write = 1; mem_result = 64'h55;
        #1 chk("lu_release", {63'd0, id_hold}, 64'd0);
        cycle();
        chk("lu_fwd_mem", ex_op_a, 64'h55);
        chk("lu_valid", {63'd0, ex_valid}, 64'd1);

        // hold_in freezes for 3 cycles; then flush beats hold_in
        savedA = ex_op_a;
        for (int i = 0; i < 3; i++) begin
            rnd(); reset = 0; flush = 0; hold_in = 1;
            cycle();
            chk("hold_op_a", ex_op_a, savedA);
            chk("hold_valid", {63'd0, ex_valid}, 64'd1);
        end
        flush = 1; hold_in = 1;
        cycle();
        chk("flush_hold", {63'd0, ex_valid}, 64'd0);

        // Reset during a load-use stall
        clr(); id_valid = 1; id_rd = 3; id_reg_write = 1; id_mem_read = 1;
        rf_data1 = 64'h1234; id_rn = 1;
        cycle();
        clr(); id_valid = 1; id_rm = 3; id_use_rm = 1; reset = 1;
        cycle();
        chk("rst_valid", {63'd0, ex_valid}, 64'd0);
        chk("rst_op_a", ex_op_a, 64'd0);
        chk("rst_rd", {59'd0, ex_rd}, 64'd0);
        reset = 0;
        #1 chk("rst_hold", {63'd0, id_hold}, 64'd0);
        cycle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rnd();
            cycle();
        end

        clr();
        waitCnt = 0;
        while (q.size() > 0 && waitCnt < 10) begin
            @(negedge clk);
            waitCnt++;
        end
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
